uart_disk_responder: RTL and testbench
======================================

Name: uart_disk_responder

Overview:
Disk-side end of the UART sector-transfer protocol; emulates the remote disk on the far end of the serial link.
Parses 4-byte command headers (0xFF, flag, LSA[7:0], LSA[15:8]) from a UART byte receiver.
For flag 0x01 (host write) it stores the next 512 received bytes into a local sector RAM. For flag 0x00 (host read) it streams 512 bytes from the sector RAM through a UART byte transmitter.
Sits between UART_R/UART_T byte engines and a synchronous block RAM.

Parameters:
SECT_W, 4, number of LSA bits used to index the sector RAM (2^SECT_W sectors); upper LSA bits ignored (wrap)
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk_CPU cycles (used only with the optional feature)

Ports:
clk_CPU  in  1  clock
rst  in  1  reset, synchronous, active-high
rx_valid  in  1  one-cycle pulse: rx_byte holds a new received byte
rx_byte  in  8  received byte
tx_start  out  1  one-cycle pulse: transmitter loads tx_byte
tx_byte  out  8  byte to send; held stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse: transmitter finished the current byte
mem_addr  out  SECT_W+9  byte address {LSA[SECT_W-1:0], offset[8:0]}
mem_we  out  1  byte write enable
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, valid one cycle after mem_addr (synchronous RAM)
busy  out  1  high in any state other than IDLE
last_lsa  out  16  LSA of the most recent accepted header
sect_wr_cnt  out  16  completed host-write sectors, wraps at 0xFFFF
err_cnt  out  8  rejected headers (bad flag) plus timeouts, saturates at 0xFF

Behaviour:
- Reset values: all outputs 0; state IDLE; offset 0; rst has priority over any concurrent rx_valid/tx_done.
- All outputs registered. Only bytes qualified by rx_valid are consumed.
- IDLE: rx_valid & rx_byte==0xFF -> FLAG. Any other byte is discarded silently.
- FLAG: on rx_valid, 0x00 -> LSA0 with op=READ; 0x01 -> LSA0 with op=WRITE; any other value -> IDLE and err_cnt+1. A second 0xFF counts as a bad flag; no resync.
- LSA0: on rx_valid, latch lsa[7:0] -> LSA1.
- LSA1: on rx_valid, latch lsa[15:8] and update last_lsa; offset<=0. op=WRITE -> RECV; op=READ -> SEND_RD.
- RECV: each rx_valid -> next cycle mem_we=1 for one cycle, mem_wdata=rx_byte, mem_addr={lsa,offset}; then offset+1. The write of offset 511 -> IDLE, sect_wr_cnt+1.
- SEND_RD: drive mem_addr={lsa,offset} -> SEND_LD.
- SEND_LD: tx_byte<=mem_rdata, tx_start=1 for one cycle -> SEND_TX.
- SEND_TX: wait for tx_done. Then offset==511 -> IDLE; else offset+1 -> SEND_RD.
- READ first-byte latency: tx_start asserts 3 cycles after the rx_valid of LSA[15:8].
- rx_valid during SEND_* is ignored. tx_done outside SEND_TX is ignored.
- tx_start never asserts outside SEND_LD. mem_we never asserts outside RECV.
- LSA >= 2^SECT_W aliases to lsa[SECT_W-1:0]; last_lsa keeps the full 16 bits.
- Reset mid-transfer: immediate return to IDLE. Partial sector data already written stays in RAM; counters clear.

Optional Feature:
RX_TIMEOUT_EN. When defined, a counter clears on every rx_valid and on every state change, and counts in FLAG, LSA0, LSA1 and RECV. Reaching TIMEOUT_CYCLES forces IDLE and increments err_cnt. Writes already done are kept.
When undefined, no counter is built, and the block waits indefinitely in those states.

Test Plan:
- Send FF 01 05 00 followed by bytes 0..511 (each value mod 256) -> 512 mem_we pulses at addresses 0xA00..0xBFF with matching data; sect_wr_cnt=1; last_lsa=0x0005; busy low afterwards.
- Then send FF 00 05 00, with tx_done returned 10 cycles after each tx_start -> exactly 512 tx_start pulses carrying 00,01,...,FF,00,...,FF; return to IDLE.
- Send 12 34 FF 07 -> bytes 12 and 34 ignored; 07 rejected; err_cnt=1; state IDLE; no mem_we and no tx_start.
- Send a header with LSA=0x0013 (SECT_W=4) -> RAM sector 3 is accessed, last_lsa=0x0013.
- Assert rst after 100 data bytes of a write -> all outputs 0. A new full write header plus 512 bytes then completes normally with sect_wr_cnt=1.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50, stop after FF 01 -> IDLE 50 cycles after the last byte; err_cnt=1.

Source files
------------

// File: rtl/uart_disk_responder.sv
// Disk-side responder for the UART sector protocol: parses FF/flag/LSA headers,
// stores host-write sectors in block RAM and streams read sectors out. Optional macro: RX_TIMEOUT_EN.
module uart_disk_responder #(
    parameter int SECT_W         = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_CPU,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_done,
    output logic [SECT_W+8:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [15:0]       last_lsa,
    output logic [15:0]       sect_wr_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FLAG, S_LSA0, S_LSA1, S_RECV, S_SEND_RD, S_SEND_LD, S_SEND_TX
    } state_t;

    state_t             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [15:0]        lsa_q, lsa_d;
    logic [8:0]         offset_q, offset_d;
    logic [SECT_W+8:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;
    logic [15:0]        last_lsa_q, last_lsa_d;
    logic [15:0]        sect_wr_cnt_q, sect_wr_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               err_inc;
`ifdef RX_TIMEOUT_EN
    logic [31:0]        tmo_q, tmo_d;
`endif

    always_comb begin
        state_d       = state_q;
        op_wr_d       = op_wr_q;
        lsa_d         = lsa_q;
        offset_d      = offset_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        tx_start_d    = 1'b0;
        tx_byte_d     = tx_byte_q;
        last_lsa_d    = last_lsa_q;
        sect_wr_cnt_d = sect_wr_cnt_q;
        err_inc       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == 8'hFF) state_d = S_FLAG;
            end
            S_FLAG: begin
                if (rx_valid) begin
                    if (rx_byte == 8'h00) begin
                        op_wr_d = 1'b0;
                        state_d = S_LSA0;
                    end else if (rx_byte == 8'h01) begin
                        op_wr_d = 1'b1;
                        state_d = S_LSA0;
                    end else begin
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_LSA0: begin
                if (rx_valid) begin
                    lsa_d[7:0] = rx_byte;
                    state_d    = S_LSA1;
                end
            end
            S_LSA1: begin
                if (rx_valid) begin
                    lsa_d[15:8] = rx_byte;
                    last_lsa_d  = {rx_byte, lsa_q[7:0]};
                    offset_d    = 9'd0;
                    if (op_wr_q) begin
                        state_d = S_RECV;
                    end else begin
                        // Address is presented on entry to SEND_RD so the RAM data is ready in SEND_LD.
                        mem_addr_d = {lsa_q[SECT_W-1:0], 9'd0};
                        state_d    = S_SEND_RD;
                    end
                end
            end
            S_RECV: begin
                // Leave only once the final byte's write strobe is on the bus.
                if (mem_we_q && mem_addr_q[8:0] == 9'h1FF) begin
                    sect_wr_cnt_d = sect_wr_cnt_q + 16'd1;
                    state_d       = S_IDLE;
                end else if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = rx_byte;
                    mem_addr_d  = {lsa_q[SECT_W-1:0], offset_q};
                    offset_d    = offset_q + 9'd1;
                end
            end
            S_SEND_RD: begin
                state_d = S_SEND_LD;
            end
            S_SEND_LD: begin
                tx_byte_d  = mem_rdata;
                tx_start_d = 1'b1;
                state_d    = S_SEND_TX;
            end
            S_SEND_TX: begin
                if (tx_done) begin
                    if (offset_q == 9'h1FF) begin
                        state_d = S_IDLE;
                    end else begin
                        offset_d   = offset_q + 9'd1;
                        mem_addr_d = {lsa_q[SECT_W-1:0], offset_q + 9'd1};
                        state_d    = S_SEND_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef RX_TIMEOUT_EN
        tmo_d = tmo_q;
        if (rx_valid || state_d != state_q) begin
            tmo_d = 32'd0;
        end else if (state_q == S_FLAG || state_q == S_LSA0 ||
                     state_q == S_LSA1 || state_q == S_RECV) begin
            if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = 32'd0;
                err_inc = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif

        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_CPU) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_wr_q       <= 1'b0;
            lsa_q         <= '0;
            offset_q      <= '0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= '0;
            busy_q        <= 1'b0;
            last_lsa_q    <= '0;
            sect_wr_cnt_q <= '0;
            err_cnt_q     <= '0;
`ifdef RX_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            op_wr_q       <= op_wr_d;
            lsa_q         <= lsa_d;
            offset_q      <= offset_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            tx_start_q    <= tx_start_d;
            tx_byte_q     <= tx_byte_d;
            busy_q        <= busy_d;
            last_lsa_q    <= last_lsa_d;
            sect_wr_cnt_q <= sect_wr_cnt_d;
            err_cnt_q     <= err_cnt_d;
`ifdef RX_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_byte     = tx_byte_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign last_lsa    = last_lsa_q;
    assign sect_wr_cnt = sect_wr_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_disk_responder.sv
// Directed bench for uart_disk_responder: a sector-level model predicts every RAM write
// and every transmitted byte; literal checks pin counters, addresses and latency.
module tb_uart_disk_responder;

    localparam int SECT_W = 4;
    localparam int AW     = SECT_W + 9;
`ifdef RX_TIMEOUT_EN
    localparam int TMO    = 50;
`else
    localparam int TMO    = 1000000;
`endif

    logic          clk_CPU = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_done = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic [15:0]   last_lsa;
    logic [15:0]   sect_wr_cnt;
    logic [7:0]    err_cnt;

    uart_disk_responder #(.SECT_W(SECT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_CPU(clk_CPU), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .last_lsa(last_lsa), .sect_wr_cnt(sect_wr_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_CPU = ~clk_CPU;

    // Synchronous block RAM attached to the responder
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk_CPU) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Sector-level model
    logic [7:0]    model_mem [0:(1<<AW)-1];
    logic [AW+7:0] exp_wr_q[$];
    logic [7:0]    exp_tx_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int wr_seen = 0;
    int tx_seen = 0;
    bit lat_armed = 1'b0;

    always @(posedge clk_CPU) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_CPU);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_cyc   = cyc;
        @(negedge clk_CPU);
        rx_valid = 1'b0;
        @(negedge clk_CPU);
    endtask

    task automatic send_header(input logic [7:0] flag, input logic [15:0] lsa);
        send_byte(8'hFF);
        send_byte(flag);
        send_byte(lsa[7:0]);
        send_byte(lsa[15:8]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk_CPU);
            n++;
        end
        check("busy_after_transfer", 32'(busy), 32'd0);
    endtask

    // Host write of n bytes with data (k*mul+add) mod 256
    task automatic write_bytes(input logic [15:0] lsa, input int n, input int mul, input int add);
        int addr;
        logic [7:0] d;
        send_header(8'h01, lsa);
        for (int k = 0; k < n; k++) begin
            d    = 8'((k * mul + add) % 256);
            addr = (int'(lsa) % (1 << SECT_W)) * 512 + k;
            model_mem[addr] = d;
            exp_wr_q.push_back({AW'(addr), d});
            send_byte(d);
        end
    endtask

    task automatic read_sector(input logic [15:0] lsa);
        int base;
        base = (int'(lsa) % (1 << SECT_W)) * 512;
        for (int k = 0; k < 512; k++) exp_tx_q.push_back(model_mem[base + k]);
        lat_armed = 1'b1;
        send_header(8'h00, lsa);
        wait_idle(20000);
    endtask

    task automatic check_all_zero();
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_last_lsa", 32'(last_lsa), 0);
        check("rst_sect_wr_cnt", 32'(sect_wr_cnt), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    // Compare process: every write strobe and transmit start against the model queues
    always @(posedge clk_CPU) begin
        logic [AW+7:0] ew;
        logic [7:0]    et;
        #1;
        if (!rst) begin
            if (mem_we) begin
                wr_seen++;
                check("mem_we_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    ew = exp_wr_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(ew[AW+7:8]));
                    check("mem_wdata", 32'(mem_wdata), 32'(ew[7:0]));
                end
            end
            if (tx_start) begin
                tx_seen++;
                check("tx_start_expected", 32'(exp_tx_q.size() != 0), 32'd1);
                if (exp_tx_q.size() != 0) begin
                    et = exp_tx_q.pop_front();
                    check("tx_byte", 32'(tx_byte), 32'(et));
                end
                if (lat_armed) begin
                    check("read_first_latency", 32'(cyc - rx_cyc), 32'd3);
                    lat_armed = 1'b0;
                end
            end
        end
    end

    // Transmitter stand-in: tx_done about 10 cycles after each tx_start
    initial begin
        forever begin
            @(posedge clk_CPU);
            #1;
            if (tx_start && !rst) begin
                repeat (10) @(negedge clk_CPU);
                tx_done = 1'b1;
                @(negedge clk_CPU);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        int wr0, tx0;
        repeat (3) @(negedge clk_CPU);
        check_all_zero();
        rst = 1'b0;
        repeat (2) @(negedge clk_CPU);

        // Full host write into sector 5
        write_bytes(16'h0005, 512, 1, 0);
        wait_idle(2000);
        check("wr5_sect_wr_cnt", 32'(sect_wr_cnt), 32'd1);
        check("wr5_last_lsa", 32'(last_lsa), 32'h0005);
        check("wr5_count", 32'(wr_seen), 32'd512);
        check("wr5_ram_first", 32'(ram[13'hA00]), 32'h00);
        check("wr5_ram_mid", 32'(ram[13'hA80]), 32'h80);
        check("wr5_ram_last", 32'(ram[13'hBFF]), 32'hFF);

        // Read it back
        read_sector(16'h0005);
        check("rd5_count", 32'(tx_seen), 32'd512);
        check("rd5_last_byte", 32'(tx_byte), 32'hFF);
        check("rd5_queue_empty", 32'(exp_tx_q.size()), 32'd0);

        // Noise then a bad flag
        wr0 = wr_seen;
        tx0 = tx_seen;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hFF);
        send_byte(8'h07);
        repeat (3) @(negedge clk_CPU);
        check("bad_err_cnt", 32'(err_cnt), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_no_write", 32'(wr_seen), 32'(wr0));
        check("bad_no_tx", 32'(tx_seen), 32'(tx0));
        check("bad_last_lsa", 32'(last_lsa), 32'h0005);

        // LSA 0x0013 aliases to sector 3; read back via another alias
        write_bytes(16'h0013, 512, 3, 1);
        wait_idle(2000);
        check("al_sect_wr_cnt", 32'(sect_wr_cnt), 32'd2);
        check("al_last_lsa", 32'(last_lsa), 32'h0013);
        check("al_ram0", 32'(ram[13'h600]), 32'h01);
        check("al_ram1", 32'(ram[13'h601]), 32'h04);
        check("al_sector5_intact", 32'(ram[13'hA05]), 32'h05);
        read_sector(16'h0023);
        check("al_last_lsa_rd", 32'(last_lsa), 32'h0023);

        // Reset in the middle of a write
        write_bytes(16'h0002, 100, 5, 7);
        @(negedge clk_CPU);
        rst = 1'b1;
        repeat (2) @(negedge clk_CPU);
        check_all_zero();
        check("mid_rst_partial_kept", 32'(ram[13'h463]), 32'hF6);
        rst = 1'b0;
        @(negedge clk_CPU);
        write_bytes(16'h0009, 512, 7, 3);
        wait_idle(2000);
        check("post_rst_sect_wr_cnt", 32'(sect_wr_cnt), 32'd1);
        check("post_rst_last_lsa", 32'(last_lsa), 32'h0009);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

`ifdef RX_TIMEOUT_EN
        // Stalled header: FF 01 then silence
        send_byte(8'hFF);
        send_byte(8'h01);
        repeat (47) @(negedge clk_CPU);
        check("tmo_busy_before", 32'(busy), 32'd1);
        repeat (2) @(negedge clk_CPU);
        check("tmo_busy_after", 32'(busy), 32'd0);
        check("tmo_err_cnt", 32'(err_cnt), 32'd1);
`endif

        repeat (5) @(negedge clk_CPU);
        check("final_wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("final_tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
